vmem_mem_responder: RTL and testbench

Physical-memory responder directly downstream of the paging/TLB stage. Serves that stage's 4-phase VMEM request/acknowledge handshake for page-directory reads, page-table reads and the final data access, using a synchronous word RAM with programmable access latency. It also keeps saturating read/write counters and a sticky out-of-range error flag for the report logic.

---
 rtl/vmem_mem_responder_pkg.sv | 16 +
 rtl/vmem_mem_responder_if.sv | 24 ++
 rtl/vmem_word_ram.sv | 37 +++
 rtl/vmem_mem_responder.sv | 125 ++++++++++++
 tb/tb_vmem_mem_responder.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vmem_mem_responder_pkg.sv
// Shared types and constants for the VMEM physical-memory responder.
package vmem_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;

    localparam logic [DATA_WIDTH-1:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    // Handshake FSM: wait for a request, count down the access latency, then hold ACK
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ACKED = 2'd2
    } state_t;

endpackage

// File: rtl/vmem_mem_responder_if.sv
// 4-phase VMEM request/acknowledge bus between the paging stage and the memory responder.
interface vmem_mem_responder_if;
    import vmem_pkg::*;

    logic                  VMEM_Request;
    logic                  VMEM_WE;
    logic [ADDR_WIDTH-1:0] VMEM_Address;
    logic [DATA_WIDTH-1:0] VMEM_WData;
    logic                  VMEM_ACK;
    logic [DATA_WIDTH-1:0] VMEM_RData;

    // Paging stage side: issues requests, receives acknowledge and read data
    modport master (
        output VMEM_Request, VMEM_WE, VMEM_Address, VMEM_WData,
        input  VMEM_ACK, VMEM_RData
    );

    // Memory side: accepts requests, returns acknowledge and read data
    modport slave (
        input  VMEM_Request, VMEM_WE, VMEM_Address, VMEM_WData,
        output VMEM_ACK, VMEM_RData
    );

endinterface

// File: rtl/vmem_word_ram.sv
// Single-port synchronous word RAM with write enable and a registered, read-enabled output.
// The array itself is never reset; only the output register is.
module vmem_word_ram #(
    parameter int MEM_WORDS_LOG2 = 12,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_we,
    input  logic                      i_re,
    input  logic [MEM_WORDS_LOG2-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0]     i_wdata,
    output logic [DATA_WIDTH-1:0]     o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1 << MEM_WORDS_LOG2)-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Storage array: written only when the responder commits a write
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Output register: updated only on a committed read so the last read value is held
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/vmem_mem_responder.sv
// Physical-memory responder for the paging/TLB stage: serves 4-phase VMEM requests
// with a programmable access latency, counts completed reads/writes and flags
// out-of-range addresses.
module vmem_mem_responder
    import vmem_pkg::*;
#(
    parameter int                    MEM_WORDS_LOG2 = 12,
    parameter int                    LATENCY        = 3,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    vmem_mem_responder_if.slave   bus,
    output logic [DATA_WIDTH-1:0] ReadCount,
    output logic [DATA_WIDTH-1:0] WriteCount,
    output logic                  AddrError
);

    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    state_t                    r_state;
    logic [3:0]                r_count;
    logic                      r_we;
    logic                      r_oob;
    logic [MEM_WORDS_LOG2-1:0] r_word;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic                      r_ack;
    logic                      r_rdataErr;
    logic [DATA_WIDTH-1:0]     r_readCount;
    logic [DATA_WIDTH-1:0]     r_writeCount;
    logic                      r_addrError;

    logic                      w_capOob;
    logic                      w_access;
    logic                      w_ramWe;
    logic                      w_ramRe;
    logic [DATA_WIDTH-1:0]     w_ramRData;
    logic [1:0]                w_unusedAddrBits;

    assign w_capOob         = |bus.VMEM_Address[ADDR_WIDTH-1:MEM_WORDS_LOG2+2];
    assign w_unusedAddrBits = bus.VMEM_Address[1:0];
    assign w_access         = (r_state == WAIT) && (r_count == 4'd0);
    assign w_ramWe          = w_access && r_we && !r_oob;
    assign w_ramRe          = w_access && !r_we && !r_oob;

    vmem_word_ram #(
        .MEM_WORDS_LOG2 (MEM_WORDS_LOG2),
        .DATA_WIDTH     (DATA_WIDTH)
    ) u_ram (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_we    (w_ramWe),
        .i_re    (w_ramRe),
        .i_addr  (r_word),
        .i_wdata (r_wdata),
        .o_rdata (w_ramRData)
    );

    // Handshake FSM with capture, latency countdown, access commit and registered status
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_we         <= 1'b0;
            r_oob        <= 1'b0;
            r_word       <= '0;
            r_wdata      <= '0;
            r_ack        <= 1'b0;
            r_rdataErr   <= 1'b0;
            r_readCount  <= '0;
            r_writeCount <= '0;
            r_addrError  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.VMEM_Request) begin
                        r_we    <= bus.VMEM_WE;
                        r_oob   <= w_capOob;
                        r_word  <= bus.VMEM_Address[MEM_WORDS_LOG2+1:2];
                        r_wdata <= bus.VMEM_WData;
                        r_count <= LAT_LOAD;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_count == 4'd0) begin
                        r_ack   <= 1'b1;
                        r_state <= ACKED;
                        if (r_oob) begin
                            r_addrError <= 1'b1;
                        end
                        if (r_we) begin
                            if (r_writeCount != '1) begin
                                r_writeCount <= r_writeCount + 1'b1;
                            end
                        end else begin
                            r_rdataErr <= r_oob;
                            if (r_readCount != '1) begin
                                r_readCount <= r_readCount + 1'b1;
                            end
                        end
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                ACKED: begin
                    if (!bus.VMEM_Request) begin
                        r_ack   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.VMEM_ACK   = r_ack;
    assign bus.VMEM_RData = r_rdataErr ? ERR_DATA : w_ramRData;
    assign ReadCount      = r_readCount;
    assign WriteCount     = r_writeCount;
    assign AddrError      = r_addrError;

endmodule

// File: tb/tb_vmem_mem_responder.sv
// Self-checking bench for vmem_mem_responder: directed scenarios plus randomized
// transfers compared against a behavioural memory model.
module tb_vmem_mem_responder;
    import vmem_pkg::*;

    localparam int          MEM_LOG2 = 12;
    localparam int          LAT      = 3;
    localparam int          DEPTH    = 1 << MEM_LOG2;
    localparam logic [31:0] ERRD     = 32'hDEADBEEF;

    logic        clk;
    logic        reset_n;
    logic [31:0] ReadCount;
    logic [31:0] WriteCount;
    logic        AddrError;

    vmem_mem_responder_if bus ();

    vmem_mem_responder #(
        .MEM_WORDS_LOG2 (MEM_LOG2),
        .LATENCY        (LAT),
        .ERR_DATA       (ERRD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .ReadCount  (ReadCount),
        .WriteCount (WriteCount),
        .AddrError  (AddrError)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    logic [31:0] modelMem [int];
    logic [31:0] modelReads  = 0;
    logic [31:0] modelWrites = 0;
    logic        modelErr    = 1'b0;
    logic [31:0] modelRData  = 0;

    int          ackCycles;
    logic [31:0] rdata;
    logic        dropped;

    // Behavioural model of one completed access
    function automatic void modelApply(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bit inRange = ((addr >> (MEM_LOG2 + 2)) == 0);
        int word    = int'((addr >> 2) % DEPTH);
        if (!inRange) modelErr = 1'b1;
        if (we) begin
            if (inRange) modelMem[word] = wdata;
            modelWrites++;
        end else begin
            modelRData = inRange ? modelMem[word] : ERRD;
            modelReads++;
        end
    endfunction

    // Runs one full handshake; reports edges-to-ACK (-1 on timeout), read data and ACK release
    task automatic doTransfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        bus.VMEM_Request = 1'b1;
        bus.VMEM_WE      = we;
        bus.VMEM_Address = addr;
        bus.VMEM_WData   = wdata;
        @(posedge clk);
        @(negedge clk);
        bus.VMEM_WE      = $urandom_range(0, 1);
        bus.VMEM_Address = $urandom;
        bus.VMEM_WData   = $urandom;
        ackCycles = -1;
        for (int i = 1; i <= LAT + 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.VMEM_ACK === 1'b1) begin
                ackCycles = i;
                break;
            end
        end
        rdata = bus.VMEM_RData;
        bus.VMEM_Request = 1'b0;
        @(posedge clk);
        @(negedge clk);
        dropped = (bus.VMEM_ACK === 1'b0);
    endtask

    task automatic applyReset();
        reset_n          = 1'b0;
        bus.VMEM_Request = 1'b0;
        bus.VMEM_WE      = 1'b0;
        bus.VMEM_Address = '0;
        bus.VMEM_WData   = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        applyReset();
        @(negedge clk);
        checkCount++;
        if (bus.VMEM_ACK !== 1'b0) $display("[TB] FAIL reset_ack: got %b expected 0", bus.VMEM_ACK);
        else passCount++;
        checkCount++;
        if (bus.VMEM_RData !== 32'h0) $display("[TB] FAIL reset_rdata: got %h expected 00000000", bus.VMEM_RData);
        else passCount++;
        checkCount++;
        if (ReadCount !== 32'h0 || WriteCount !== 32'h0)
            $display("[TB] FAIL reset_counts: got r=%0d w=%0d expected 0/0", ReadCount, WriteCount);
        else passCount++;
        checkCount++;
        if (AddrError !== 1'b0) $display("[TB] FAIL reset_addrerr: got %b expected 0", AddrError);
        else passCount++;
    endtask

    task automatic test_write_read();
        doTransfer(1'b1, 32'h1000, 32'h00002000);
        modelApply(1'b1, 32'h1000, 32'h00002000);
        doTransfer(1'b0, 32'h1000, 32'h0);
        modelApply(1'b0, 32'h1000, 32'h0);
        checkCount++;
        if (rdata !== modelRData) $display("[TB] FAIL wr_rd_data: got %h expected %h", rdata, modelRData);
        else passCount++;
        checkCount++;
        if (WriteCount !== modelWrites || ReadCount !== modelReads)
            $display("[TB] FAIL wr_rd_counts: got w=%0d r=%0d expected w=%0d r=%0d", WriteCount, ReadCount, modelWrites, modelReads);
        else passCount++;
    endtask

    task automatic test_latency();
        logic [31:0] d = $urandom;
        doTransfer(1'b1, 32'h0040, d);
        modelApply(1'b1, 32'h0040, d);
        checkCount++;
        if (ackCycles != LAT) $display("[TB] FAIL latency_ack: got %0d edges expected %0d", ackCycles, LAT);
        else passCount++;
        checkCount++;
        if (!dropped) $display("[TB] FAIL latency_release: got ack=1 expected ack=0 one edge after drop");
        else passCount++;
    endtask

    task automatic test_page_walk();
        logic [31:0] addrs [3] = '{32'h1000, 32'h2004, 32'h5010};
        logic [31:0] datas [3] = '{32'h00002000, 32'h00005000, 32'hCAFEF00D};
        for (int i = 0; i < 3; i++) begin
            doTransfer(1'b1, addrs[i], datas[i]);
            modelApply(1'b1, addrs[i], datas[i]);
        end
        for (int i = 0; i < 3; i++) begin
            doTransfer(1'b0, addrs[i], 32'h0);
            modelApply(1'b0, addrs[i], 32'h0);
            checkCount++;
            if (rdata !== modelRData) $display("[TB] FAIL walk_read%0d: got %h expected %h", i, rdata, modelRData);
            else passCount++;
        end
    endtask

    task automatic test_out_of_range();
        doTransfer(1'b1, 32'h0000_0000, 32'h1234_5678);
        modelApply(1'b1, 32'h0000_0000, 32'h1234_5678);
        doTransfer(1'b0, 32'h0010_0000, 32'h0);
        modelApply(1'b0, 32'h0010_0000, 32'h0);
        checkCount++;
        if (rdata !== modelRData) $display("[TB] FAIL oob_rdata: got %h expected %h", rdata, modelRData);
        else passCount++;
        checkCount++;
        if (AddrError !== modelErr) $display("[TB] FAIL oob_flag: got %b expected %b", AddrError, modelErr);
        else passCount++;
        doTransfer(1'b1, 32'h0010_0000, 32'h0);
        modelApply(1'b1, 32'h0010_0000, 32'h0);
        doTransfer(1'b0, 32'h0000_0000, 32'h0);
        modelApply(1'b0, 32'h0000_0000, 32'h0);
        checkCount++;
        if (rdata !== modelRData) $display("[TB] FAIL oob_word0: got %h expected %h", rdata, modelRData);
        else passCount++;
        checkCount++;
        if (AddrError !== modelErr) $display("[TB] FAIL oob_sticky: got %b expected %b", AddrError, modelErr);
        else passCount++;
    endtask

    task automatic test_abort();
        logic [31:0] d = $urandom;
        int highCycles = 0;
        @(negedge clk);
        bus.VMEM_Request = 1'b1;
        bus.VMEM_WE      = 1'b1;
        bus.VMEM_Address = 32'h3000;
        bus.VMEM_WData   = d;
        @(posedge clk);
        @(negedge clk);
        bus.VMEM_Request = 1'b0;
        for (int i = 0; i < LAT + 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.VMEM_ACK === 1'b1) highCycles++;
        end
        modelApply(1'b1, 32'h3000, d);
        checkCount++;
        if (highCycles != 1) $display("[TB] FAIL abort_pulse: got %0d ack cycles expected 1", highCycles);
        else passCount++;
        checkCount++;
        if (WriteCount !== modelWrites) $display("[TB] FAIL abort_wcount: got %0d expected %0d", WriteCount, modelWrites);
        else passCount++;
        doTransfer(1'b0, 32'h3000, 32'h0);
        modelApply(1'b0, 32'h3000, 32'h0);
        checkCount++;
        if (rdata !== modelRData) $display("[TB] FAIL abort_data: got %h expected %h", rdata, modelRData);
        else passCount++;
    endtask

    task automatic test_reset_midop();
        logic [31:0] oldD = $urandom;
        logic [31:0] newD = ~oldD;
        doTransfer(1'b1, 32'h1004, oldD);
        modelApply(1'b1, 32'h1004, oldD);
        @(negedge clk);
        bus.VMEM_Request = 1'b1;
        bus.VMEM_WE      = 1'b1;
        bus.VMEM_Address = 32'h1004;
        bus.VMEM_WData   = newD;
        @(posedge clk);
        @(negedge clk);
        reset_n          = 1'b0;
        bus.VMEM_Request = 1'b0;
        #1;
        modelReads  = 0;
        modelWrites = 0;
        modelErr    = 1'b0;
        modelRData  = 0;
        checkCount++;
        if (bus.VMEM_ACK !== 1'b0) $display("[TB] FAIL midrst_ack: got %b expected 0", bus.VMEM_ACK);
        else passCount++;
        checkCount++;
        if (ReadCount !== 32'h0 || WriteCount !== 32'h0 || AddrError !== 1'b0)
            $display("[TB] FAIL midrst_status: got r=%0d w=%0d err=%b expected 0/0/0", ReadCount, WriteCount, AddrError);
        else passCount++;
        checkCount++;
        if (bus.VMEM_RData !== 32'h0) $display("[TB] FAIL midrst_rdata: got %h expected 00000000", bus.VMEM_RData);
        else passCount++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        doTransfer(1'b0, 32'h1004, 32'h0);
        modelApply(1'b0, 32'h1004, 32'h0);
        checkCount++;
        if (rdata !== modelRData) $display("[TB] FAIL midrst_olddata: got %h expected %h", rdata, modelRData);
        else passCount++;
    endtask

    task automatic test_random();
        logic [31:0] written [$];
        for (int n = 0; n < 40; n++) begin
            logic        we;
            logic [31:0] addr;
            logic [31:0] d = $urandom;
            int          kind = $urandom_range(0, 9);
            if (kind == 0) begin
                we   = $urandom_range(0, 1);
                addr = $urandom | 32'h0000_4000;
            end else if (kind < 5 || written.size() == 0) begin
                we   = 1'b1;
                addr = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3));
                written.push_back(addr);
            end else begin
                we   = 1'b0;
                addr = written[$urandom_range(0, written.size() - 1)];
            end
            doTransfer(we, addr, d);
            modelApply(we, addr, d);
            checkCount++;
            if (ackCycles != LAT || !dropped)
                $display("[TB] FAIL rand_handshake%0d: got ack after %0d edges release=%b expected %0d/1", n, ackCycles, dropped, LAT);
            else passCount++;
            checkCount++;
            if (rdata !== modelRData) $display("[TB] FAIL rand_rdata%0d: got %h expected %h", n, rdata, modelRData);
            else passCount++;
        end
        checkCount++;
        if (ReadCount !== modelReads || WriteCount !== modelWrites || AddrError !== modelErr)
            $display("[TB] FAIL rand_status: got r=%0d w=%0d err=%b expected r=%0d w=%0d err=%b",
                     ReadCount, WriteCount, AddrError, modelReads, modelWrites, modelErr);
        else passCount++;
    endtask

    // Scenario sequence followed by the one summary line
    initial begin
        test_reset();
        test_write_read();
        test_latency();
        test_page_walk();
        test_out_of_range();
        test_abort();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
